// File: rtl/sram_controller_if.sv
// Cache-side request/response bus of the SRAM controller.
// master: the data cache controller; slave: the SRAM controller.
interface sram_controller_if;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        write;
    logic        read;
    logic [63:0] rdata;
    logic        ready;

    modport master (
        output address,
        output wdata,
        output write,
        output read,
        input  rdata,
        input  ready
    );

    modport slave (
        input  address,
        input  wdata,
        input  write,
        input  read,
        output rdata,
        output ready
    );
endinterface

// File: rtl/sram_controller.sv
// SRAM controller: services single-outstanding read-block (4 x 16 bit) and
// write-word (2 x 16 bit) requests from the data cache against a 256K x 16
// asynchronous SRAM. Fixed latency, one-cycle ready pulse on completion.
module sram_controller #(
    parameter int unsigned BASE_ADDR  = 1024,
    parameter int unsigned ACC_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    sram_controller_if.slave bus,
    output logic [17:0]      SRAM_ADDR,
    inout  wire  [15:0]      SRAM_DQ,
    output logic             SRAM_WE_N,
    output logic             SRAM_OE_N,
    output logic             SRAM_CE_N,
    output logic             SRAM_UB_N,
    output logic             SRAM_LB_N
);
    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    localparam logic [2:0]  LastCnt = 3'(ACC_CYCLES - 1);
    localparam logic [31:0] Base    = 32'(BASE_ADDR);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  k_q, k_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [63:0] rdata_q;
    logic [31:0] off;
    logic        unused_off_hi;
    logic        last_clk;
    logic [15:0] dq_out;

    // Only bits [18:0] of the offset reach the 18-bit halfword address.
    assign off           = addr_q - Base;
    assign unused_off_hi = ^off[31:19];
    assign last_clk      = (cnt_q == LastCnt);

    assign dq_out  = k_q[0] ? wdata_q[31:16] : wdata_q[15:0];
    assign SRAM_DQ = (state_q == StWr) ? dq_out : 16'bz;

    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign bus.ready = (state_q == StDone);
    assign bus.rdata = rdata_q;

    // State register, access counters and latched request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            k_q     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Capture each read halfword on the last clock of its access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (state_q == StRd && last_clk) begin
            rdata_q[{k_q, 4'b0000} +: 16] <= SRAM_DQ;
        end
    end

    // Next state and SRAM strobes
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                k_d   = '0;
                // Write wins when both requests are high.
                if (bus.write) begin
                    state_d = StWr;
                    addr_d  = bus.address;
                    wdata_d = bus.wdata;
                end else if (bus.read) begin
                    state_d = StRd;
                    addr_d  = bus.address;
                    wdata_d = bus.wdata;
                end
            end
            StRd: begin
                SRAM_OE_N = 1'b0;
                SRAM_ADDR = {off[18:3], k_q};
                cnt_d     = cnt_q + 3'd1;
                if (last_clk) begin
                    cnt_d = '0;
                    k_d   = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        state_d = StDone;
                    end
                end
            end
            StWr: begin
                SRAM_ADDR = {off[18:2], k_q[0]};
                // WE rises one clock before address/data move on, giving hold time.
                SRAM_WE_N = last_clk;
                cnt_d     = cnt_q + 3'd1;
                if (last_clk) begin
                    cnt_d = '0;
                    k_d   = k_q + 2'd1;
                    if (k_q[0]) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end
endmodule
